// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: reads a burst of `len` words from a first-word-fall-through FIFO
// and presents them on a valid/ready stream through a 2-entry output buffer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, len          burst request and word count (sampled in IDLE only)
//   abort               cancel the current burst, flush the buffer, no done pulse
//   fifo_empty          FIFO empty flag
//   fifo_rd_data        FIFO head word (valid while fifo_empty=0)
//   fifo_rd             FIFO pop strobe
//   m_valid, m_ready    stream handshake
//   m_data, m_last      stream word and end-of-burst marker
//   busy                burst in progress (RUN or DRAIN)
//   done                one-cycle pulse after the last word is accepted
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OCC_W-1:0]      r_occ;
    logic [LEN_WIDTH-1:0]  r_rd_left;
    logic [LEN_WIDTH-1:0]  r_out_left;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic                  r_done;

    logic w_kill;
    logic w_load;
    logic w_fill;
    logic w_pop;
    logic w_last_pop;

    // Control strobes; abort (and rst for the external pop) dominate everything else.
    always_comb begin
        w_kill     = abort && (r_state != ST_IDLE);
        w_load     = (r_state == ST_IDLE) && start && (len != '0);
        // Fill decision depends only on occupancy, never on m_ready.
        w_fill     = (r_state == ST_RUN) && !fifo_empty && (r_rd_left != '0)
                     && (r_occ < OCC_W'(2)) && !w_kill && !rst;
        w_pop      = (r_occ != '0) && m_ready && !w_kill;
        w_last_pop = (r_state == ST_DRAIN) && w_pop && (r_out_left == LEN_WIDTH'(1));
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_load) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_fill && (r_rd_left == LEN_WIDTH'(1))) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_pop) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_kill) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, output buffer and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= '0;
            r_rd_left  <= '0;
            r_out_left <= '0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_pop;
            if (w_kill) begin
                r_occ      <= '0;
                r_rd_left  <= '0;
                r_out_left <= '0;
            end else begin
                if (w_load) begin
                    r_rd_left  <= len;
                    r_out_left <= len;
                end else begin
                    if (w_fill) r_rd_left  <= r_rd_left - LEN_WIDTH'(1);
                    if (w_pop)  r_out_left <= r_out_left - LEN_WIDTH'(1);
                end
                case ({w_fill, w_pop})
                    2'b10: begin
                        if (r_occ == '0) r_buf0 <= fifo_rd_data;
                        else             r_buf1 <= fifo_rd_data;
                        r_occ <= r_occ + OCC_W'(1);
                    end
                    2'b01: begin
                        r_buf0 <= r_buf1;
                        r_occ  <= r_occ - OCC_W'(1);
                    end
                    // Fill only happens with occupancy 1 here, so the new word becomes head.
                    2'b11: r_buf0 <= fifo_rd_data;
                    default: ;
                endcase
            end
        end
    end

    assign fifo_rd = w_fill;
    assign m_valid = (r_occ != '0);
    assign m_data  = r_buf0;
    assign m_last  = (r_occ != '0) && (r_out_left == LEN_WIDTH'(1));
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: a bench-side FIFO model, a scoreboard of expected
// stream words filled when bursts are issued, and a monitor that checks every handshake.
module tb_fifo_burst_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned LW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          abort;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd(fifo_rd),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    // Bench FIFO: pushes from the stimulus thread, pops on fifo_rd.
    logic [DW-1:0] mem [0:1023];
    int rp = 0;
    int wp = 0;
    assign fifo_empty   = (rp == wp);
    assign fifo_rd_data = mem[rp[9:0]];
    always @(posedge clk) if (fifo_rd) rp <= rp + 1;

    // Reference model state.
    logic [DW-1:0] ref_fifo[$];     // FIFO contents in order, including words still to be pushed
    logic [DW-1:0] phys_pending[$]; // planned words not yet pushed into the bench FIFO
    exp_t          exp_q[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  hs_cnt   = 0;
    int  rd_cnt   = 0;
    bit  mon_en   = 1'b0;
    bit  ready_rand = 1'b0;
    bit  prev_last_hs = 1'b0;
    bit  prev_stall   = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic hs;
        exp_t e;
        if (mon_en) begin
            chk("done_pulse", 32'(done), 32'(prev_last_hs));
            chk("rd_when_empty", 32'(fifo_rd & fifo_empty), 32'd0);
            if (fifo_rd) rd_cnt++;
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            hs = m_valid && m_ready && !abort && !rst;
            prev_last_hs = 1'b0;
            if (hs) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word got=%0h exp=none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", 32'(m_data), 32'(e.data));
                    chk("stream_last", 32'(m_last), 32'(e.last));
                    prev_last_hs = e.last;
                end
            end else if (m_valid && exp_q.size() != 0) begin
                chk("last_flag", 32'(m_last), 32'(exp_q[0].last));
            end
            prev_stall = m_valid && !m_ready && !abort && !rst;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ready_rand) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_plan(input logic [DW-1:0] w);
        ref_fifo.push_back(w);
        phys_pending.push_back(w);
    endtask

    task automatic push_now();
        mem[wp[9:0]] = phys_pending.pop_front();
        wp++;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            push_plan(16'($urandom));
            push_now();
        end
    endtask

    // A burst of L words delivers the next L FIFO words, last flag on the L-th.
    task automatic sb_burst(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = ref_fifo.pop_front();
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Cancelled burst: `lost` words were popped but never delivered; the rest stay in the FIFO.
    task automatic model_cancel(input int lost);
        for (int i = 0; i < lost; i++) void'(exp_q.pop_front());
        while (exp_q.size() != 0) ref_fifo.push_front(exp_q.pop_back().data);
    endtask

    task automatic do_start(input int n, input bit accepted);
        len   = LW'(n);
        start = 1'b1;
        if (accepted) sb_burst(n);
        tick();
        start = 1'b0;
    endtask

    // Run until done, pushing planned words at random (rate 0: every cycle).
    task automatic finish_burst(input int limit, input int rate);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (phys_pending.size() != 0 && $urandom_range(0, rate) == 0) push_now();
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int rd0;
        bit hit;
        logic [DW-1:0] w0;
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; m_ready = 1'b1;

        // Reset state
        tick();
        mon_en = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_rd", 32'(fifo_rd), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // 0x0001..0x0004, len=4, always ready: words at N+2..N+5, done at N+6
        for (int i = 1; i <= 4; i++) begin
            push_plan(16'(i));
            push_now();
        end
        rd0 = rd_cnt;
        do_start(4, 1'b1);
        chk("lat_rd_n1", 32'(fifo_rd), 32'd1);
        chk("lat_valid_n1", 32'(m_valid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_valid", 32'(m_valid), 32'd1);
            chk("seq_data", 32'(m_data), 32'(i));
            chk("seq_last", 32'(m_last), 32'(i == 4));
        end
        tick();
        chk("seq_done", 32'(done), 32'd1);
        chk("seq_rd_count", 32'(rd_cnt - rd0), 32'd4);
        tick();

        // len=3, sink stalled 5 cycles: only 2 reads, head word held
        preload(3);
        w0 = ref_fifo[0];
        m_ready = 1'b0;
        rd0 = rd_cnt;
        do_start(3, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("stall_rd_count", 32'(rd_cnt - rd0), 32'd2);
        chk("stall_head", 32'(m_data), 32'(w0));
        m_ready = 1'b1;
        finish_burst(50, 0);

        // Empty FIFO: stall 10 cycles, then words arrive
        push_plan(16'($urandom));
        push_plan(16'($urandom));
        do_start(2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("empty_busy", 32'(busy), 32'd1);
            chk("empty_no_rd", 32'(fifo_rd), 32'd0);
            tick();
        end
        finish_burst(50, 0);

        // len=8 with 8 preloaded, abort in the cycle after the 3rd handshake.
        // Then 4 words have been read (3 delivered, 1 in the buffer and flushed).
        preload(8);
        base = hs_cnt;
        do_start(8, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (hs_cnt - base >= 3) hit = 1'b1;
            else tick();
        end
        chk("abort_reach_3hs", 32'(hs_cnt - base), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        model_cancel(1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(m_valid), 32'd0);
        tick();
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_fifo_left", 32'(wp - rp), 32'd4);
        do_start(4, 1'b1);
        finish_burst(50, 0);

        // rst mid-burst with buffer full, start in the same cycle
        preload(4);
        m_ready = 1'b0;
        do_start(4, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        start = 1'b1;
        len = LW'(4);
        tick();
        rst = 1'b0;
        start = 1'b0;
        model_cancel(2);
        chk("rstmid_rd", 32'(fifo_rd), 32'd0);
        chk("rstmid_valid", 32'(m_valid), 32'd0);
        chk("rstmid_last", 32'(m_last), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        tick();
        chk("rstmid_start_ignored", 32'(busy), 32'd0);
        chk("rstmid_fifo_left", 32'(wp - rp), 32'd2);
        m_ready = 1'b1;
        do_start(2, 1'b1);
        finish_burst(50, 0);

        // start with len=0, then start while busy: both ignored
        preload(2);
        do_start(0, 1'b0);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_rd", 32'(fifo_rd), 32'd0);
        tick();
        chk("len0_busy2", 32'(busy), 32'd0);
        chk("len0_done", 32'(done), 32'd0);
        preload(3);
        do_start(2, 1'b1);
        do_start(3, 1'b0);
        finish_burst(50, 0);
        chk("busy_start_left", 32'(wp - rp), 32'd3);
        do_start(3, 1'b1);
        finish_burst(50, 0);

        // Maximum length burst
        preload(255);
        rd0 = rd_cnt;
        do_start(255, 1'b1);
        finish_burst(400, 0);
        chk("max_rd_count", 32'(rd_cnt - rd0), 32'd255);

        // Randomized bursts: random length, partial preload, random ready and push timing
        ready_rand = 1'b1;
        for (int it = 0; it < 25; it++) begin
            int n;
            int p;
            n = int'($urandom_range(1, 12));
            p = int'($urandom_range(0, n));
            for (int i = 0; i < n; i++) push_plan(16'($urandom));
            for (int i = 0; i < p; i++) push_now();
            do_start(n, 1'b1);
            finish_burst(300, 2);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end
        ready_rand = 1'b0;
        m_ready = 1'b1;

        tick();
        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("fifo_empty_end", 32'(wp - rp), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
